// File: rtl/pc_sequencer.sv
// Program-counter sequencer: +4 stepping, prioritised redirects, stall with one captured redirect.
// Optional macro PC_SEQ_DELAY_SLOT_EN ties flush_o low so the branch delay slot executes.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        isJOrJal,
  input  logic        Compare_o,
  input  logic        isJrOrJalr,
  input  logic [31:0] NPC_o,
  input  logic [31:0] RegFile_o_1,
  output logic [31:0] PC_o,
  output logic [31:0] ADD4_o,
  output logic        flush_o,
  output logic        pending_o,
  output logic        addr_err_o
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    PEND = 2'd2
  } seqState_t;

  seqState_t   state;
  seqState_t   stateNext;
  logic [31:0] pcQ;
  logic [31:0] pendTarget;
  logic        errQ;

  logic        redirValid;
  logic [31:0] redirTarget;
  logic        loadPc;
  logic        loadRedirect;
  logic        latchTarget;
  logic [31:0] pcLoadValue;

  // Direct jumps and taken branches outrank register-indirect jumps.
  assign redirValid  = isJOrJal | Compare_o | isJrOrJalr;
  assign redirTarget = (isJOrJal | Compare_o) ? NPC_o : RegFile_o_1;
  assign ADD4_o      = pcQ + 32'd4;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= RUN;
      pcQ        <= RESET_PC;
      pendTarget <= '0;
      errQ       <= 1'b0;
    end else begin
      state <= stateNext;
      if (loadPc) pcQ <= {pcLoadValue[31:2], 2'b00};
      if (latchTarget) pendTarget <= redirTarget;
      if (loadRedirect && (pcLoadValue[1:0] != 2'b00)) errQ <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves stateNext unassigned (no latch).
    stateNext = state;
    unique case (state)
      RUN, HOLD: begin
        if (!stall_i)        stateNext = RUN;
        else if (redirValid) stateNext = PEND;
        else                 stateNext = HOLD;
      end
      PEND:    if (!stall_i) stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    loadPc       = 1'b0;
    loadRedirect = 1'b0;
    latchTarget  = 1'b0;
    pcLoadValue  = ADD4_o;
    unique case (state)
      RUN, HOLD: begin
        if (!stall_i) begin
          loadPc = 1'b1;
          if (redirValid) begin
            loadRedirect = 1'b1;
            pcLoadValue  = redirTarget;
          end
        end else begin
          latchTarget = redirValid;
        end
      end
      // The captured target wins; live redirect inputs are ignored here.
      PEND: begin
        if (!stall_i) begin
          loadPc       = 1'b1;
          loadRedirect = 1'b1;
          pcLoadValue  = pendTarget;
        end
      end
      default: ;
    endcase
  end

`ifdef PC_SEQ_DELAY_SLOT_EN
  assign flush_o = 1'b0;
`else
  logic flushQ;

  always_ff @(posedge clk) begin
    if (rst) flushQ <= 1'b0;
    else     flushQ <= loadRedirect;
  end

  assign flush_o = flushQ;
`endif

  assign PC_o       = pcQ;
  assign pending_o  = (state == PEND);
  assign addr_err_o = errQ;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic against a queue-based model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
`ifdef PC_SEQ_DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif
  localparam logic FLUSH_ON_REDIRECT = !DELAY_SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        isJOrJal = 1'b0;
  logic        Compare_o = 1'b0;
  logic        isJrOrJalr = 1'b0;
  logic [31:0] NPC_o = '0;
  logic [31:0] RegFile_o_1 = '0;
  logic [31:0] PC_o;
  logic [31:0] ADD4_o;
  logic        flush_o;
  logic        pending_o;
  logic        addr_err_o;

  int checks = 0;
  int errors = 0;

  // Reference model: PC value, at most one captured redirect, flush and sticky error.
  logic [31:0] mPc = RESET_PC;
  logic [31:0] mQ[$];
  logic        mFlush = 1'b0;
  logic        mErr = 1'b0;

  pc_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .isJOrJal   (isJOrJal),
    .Compare_o  (Compare_o),
    .isJrOrJalr (isJrOrJalr),
    .NPC_o      (NPC_o),
    .RegFile_o_1(RegFile_o_1),
    .PC_o       (PC_o),
    .ADD4_o     (ADD4_o),
    .flush_o    (flush_o),
    .pending_o  (pending_o),
    .addr_err_o (addr_err_o)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    logic        redir;
    logic [31:0] tgt;
    if (rst) begin
      mPc = RESET_PC;
      mQ.delete();
      mFlush = 1'b0;
      mErr = 1'b0;
      return;
    end
    mFlush = 1'b0;
    redir = 1'b1;
    if (isJOrJal || Compare_o) tgt = NPC_o;
    else if (isJrOrJalr)       tgt = RegFile_o_1;
    else begin
      redir = 1'b0;
      tgt = '0;
    end
    if (stall_i) begin
      if (mQ.size() == 0 && redir) mQ.push_back(tgt);
    end else begin
      if (mQ.size() != 0) begin
        tgt = mQ.pop_front();
        redir = 1'b1;
      end
      if (redir) begin
        if (tgt[1:0] != 2'b00) mErr = 1'b1;
        mPc = {tgt[31:2], 2'b00};
        mFlush = FLUSH_ON_REDIRECT;
      end else begin
        mPc = mPc + 32'd4;
      end
    end
  endtask

  // Advance one edge, update the model, then settle 1 time unit for sampling.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    stall_i = 1'b0;
    isJOrJal = 1'b0;
    Compare_o = 1'b0;
    isJrOrJalr = 1'b0;
    NPC_o = '0;
    RegFile_o_1 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (PC_o !== RESET_PC) begin
      errors++;
      $display("FAIL reset_pc got %h want %h", PC_o, RESET_PC);
    end
    checks++;
    if ({flush_o, pending_o, addr_err_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000", {flush_o, pending_o, addr_err_o});
    end
  endtask

  task automatic test_sequential();
    logic [31:0] want[3];
    want = '{32'h3004, 32'h3008, 32'h300C};
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (PC_o !== want[i] || flush_o !== 1'b0) begin
        errors++;
        $display("FAIL seq_pc%0d got %h/%b want %h/0", i, PC_o, flush_o, want[i]);
      end
    end
  endtask

  task automatic test_jump();
    do_reset();
    step();
    step();
    isJOrJal = 1'b1;
    Compare_o = 1'b1;
    NPC_o = 32'h4000;
    RegFile_o_1 = 32'h5000;
    step();
    clear_inputs();
    checks++;
    if (PC_o !== 32'h4000 || flush_o !== FLUSH_ON_REDIRECT) begin
      errors++;
      $display("FAIL jump got %h/%b want 00004000/%b", PC_o, flush_o, FLUSH_ON_REDIRECT);
    end
    step();
    checks++;
    if (PC_o !== 32'h4004 || flush_o !== 1'b0) begin
      errors++;
      $display("FAIL jump_after got %h/%b want 00004004/0", PC_o, flush_o);
    end
  endtask

  task automatic test_stall_pending();
    logic [31:0] held;
    held = PC_o;
    stall_i = 1'b1;
    isJrOrJalr = 1'b1;
    RegFile_o_1 = 32'h6000;
    step();
    isJrOrJalr = 1'b0;
    isJOrJal = 1'b1;
    NPC_o = 32'h7000;
    step();
    isJOrJal = 1'b0;
    step();
    checks++;
    if (pending_o !== 1'b1 || PC_o !== held) begin
      errors++;
      $display("FAIL stall_hold got %h/%b want %h/1", PC_o, pending_o, held);
    end
    stall_i = 1'b0;
    step();
    checks++;
    if (PC_o !== 32'h6000 || pending_o !== 1'b0 || flush_o !== FLUSH_ON_REDIRECT) begin
      errors++;
      $display("FAIL stall_release got %h/%b/%b want 00006000/0/%b", PC_o, pending_o, flush_o,
               FLUSH_ON_REDIRECT);
    end
  endtask

  task automatic test_misaligned();
    isJrOrJalr = 1'b1;
    RegFile_o_1 = 32'h6002;
    step();
    clear_inputs();
    checks++;
    if (PC_o !== 32'h6000 || addr_err_o !== 1'b1) begin
      errors++;
      $display("FAIL misaligned got %h/%b want 00006000/1", PC_o, addr_err_o);
    end
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (addr_err_o !== 1'b1 || PC_o !== 32'h6028) begin
      errors++;
      $display("FAIL err_sticky got %b/%h want 1/00006028", addr_err_o, PC_o);
    end
  endtask

  task automatic test_reset_in_pend();
    stall_i = 1'b1;
    isJOrJal = 1'b1;
    NPC_o = 32'h8000;
    step();
    checks++;
    if (pending_o !== 1'b1) begin
      errors++;
      $display("FAIL pend_enter got %b want 1", pending_o);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_inputs();
    checks++;
    if (PC_o !== RESET_PC || pending_o !== 1'b0 || addr_err_o !== 1'b0) begin
      errors++;
      $display("FAIL pend_reset got %h/%b/%b want %h/0/0", PC_o, pending_o, addr_err_o, RESET_PC);
    end
    step();
    checks++;
    if (PC_o !== 32'h3004 || flush_o !== 1'b0) begin
      errors++;
      $display("FAIL pend_stale got %h/%b want 00003004/0", PC_o, flush_o);
    end
  endtask

  task automatic test_wrap();
    isJOrJal = 1'b1;
    NPC_o = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    checks++;
    if (PC_o !== 32'hFFFF_FFFC || ADD4_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_add4 got %h/%h want fffffffc/00000000", PC_o, ADD4_o);
    end
    step();
    checks++;
    if (PC_o !== 32'h0 || addr_err_o !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pc got %h/%b want 00000000/0", PC_o, addr_err_o);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      stall_i = ($urandom_range(0, 99) < 40);
      isJOrJal = ($urandom_range(0, 99) < 10);
      Compare_o = ($urandom_range(0, 99) < 10);
      isJrOrJalr = ($urandom_range(0, 99) < 12);
      NPC_o = $urandom();
      RegFile_o_1 = $urandom();
      if ($urandom_range(0, 3) != 0) NPC_o[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) RegFile_o_1[1:0] = 2'b00;
      step();
      checks++;
      if (PC_o !== mPc || ADD4_o !== mPc + 32'd4) begin
        errors++;
        $display("FAIL rnd_pc@%0d got %h/%h want %h/%h", n, PC_o, ADD4_o, mPc, mPc + 32'd4);
      end
      checks++;
      if (flush_o !== mFlush || pending_o !== (mQ.size() != 0) || addr_err_o !== mErr) begin
        errors++;
        $display("FAIL rnd_flags@%0d got %b%b%b want %b%b%b", n, flush_o, pending_o, addr_err_o,
                 mFlush, (mQ.size() != 0), mErr);
      end
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_sequential();
    test_jump();
    test_stall_pending();
    test_misaligned();
    test_reset_in_pend();
    test_wrap();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port stall_i  input  1  freeze PC (hazard unit request).
REQ-005 SHALL have port isJOrJal  input  1  J/JAL decoded this cycle.
REQ-006 SHALL have port Compare_o  input  1  branch condition true this cycle.
REQ-007 SHALL have port isJrOrJalr  input  1  JR/JALR decoded this cycle.
REQ-008 SHALL have port NPC_o  input  32  jump/branch target.
REQ-009 SHALL have port RegFile_o_1  input  32  register target for JR/JALR.
REQ-010 SHALL have port PC_o  output  32  current PC to instruction memory.
REQ-011 SHALL have port ADD4_o  output  32  PC_o + 4, combinational.
REQ-012 SHALL have port flush_o  output  1  kill the IF/ID instruction, registered.
REQ-013 SHALL have port pending_o  output  1  redirect captured during stall, awaiting release.
REQ-014 SHALL have port addr_err_o  output  1  sticky misaligned-target flag.

Function
REQ-015 SHALL select the redirect source with fixed priority: (isJOrJal | Compare_o) -> NPC_o, else isJrOrJalr -> RegFile_o_1, else no redirect.
REQ-016 SHALL implement states RUN, HOLD and PEND, encoded in 2 bits.
REQ-017 In RUN with stall_i=0: PC_o SHALL load the redirect target if a redirect is present, else ADD4_o, at the next edge.
REQ-018 In RUN with stall_i=1: PC_o SHALL hold; the next state SHALL be PEND (target latched) if a redirect is present, else HOLD.
REQ-019 In HOLD: PC_o SHALL hold while stall_i=1; a redirect seen in HOLD SHALL be latched and the state SHALL move to PEND.
REQ-020 HOLD with stall_i=0 SHALL behave as RUN for that cycle, including the redirect/+4 load, and the state SHALL return to RUN.
REQ-021 In PEND: PC_o SHALL hold while stall_i=1; further redirects SHALL be ignored, so the first captured target wins.
REQ-022 In PEND with stall_i=0: PC_o SHALL load the latched target, pending_o SHALL clear, and the state SHALL return to RUN; live redirect inputs that cycle SHALL be ignored.
REQ-023 pending_o SHALL be 1 exactly while the state is PEND.
REQ-024 flush_o SHALL be 1 for exactly the one cycle following any edge at which PC_o loaded a redirect target, and 0 otherwise.
REQ-025 A target with bits [1:0]!=0 SHALL load PC_o with bits [1:0] forced to 0 and SHALL set addr_err_o, which stays set until rst.
REQ-026 ADD4_o SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0), with no error.

Reset
REQ-027 On rst=1 at an edge: PC_o=RESET_PC, state=RUN, flush_o=0, pending_o=0, addr_err_o=0, latched target=0.
REQ-028 rst SHALL override stall_i and all redirect inputs, and SHALL discard any pending redirect when asserted mid-operation.

Configuration
REQ-029 Macro PC_SEQ_DELAY_SLOT_EN: when defined, flush_o SHALL be constant 0 (MIPS branch delay slot executes); when undefined, flush_o SHALL behave per REQ-024.
REQ-030 PC_o, pending_o and addr_err_o SHALL behave identically with and without PC_SEQ_DELAY_SLOT_EN.

Verification
REQ-031 Reset then 3 free-running cycles -> PC_o = 3000, 3004, 3008, 300C; flush_o=0.
REQ-032 At PC=3008: assert isJOrJal and Compare_o with NPC_o=4000 and RegFile_o_1=5000 -> next PC_o=4000; flush_o=1 for one cycle (0 with macro defined).
REQ-033 stall_i=1 for 3 cycles, with isJrOrJalr pulsed (RegFile_o_1=6000) in stall cycle 1, then NPC_o=7000 with isJOrJal in stall cycle 2 -> pending_o=1, PC_o held; on release PC_o=6000, pending_o=0, flush_o=1.
REQ-034 Redirect with RegFile_o_1=6002 -> PC_o=6000 and addr_err_o=1, still 1 after 10 further cycles.
REQ-035 rst asserted while in PEND -> next PC_o=3000, pending_o=0, addr_err_o=0; the stale target is never loaded.
REQ-036 PC forced by redirect to FFFF_FFFC with no further redirect -> ADD4_o=0 and next PC_o=0.
